flash_playback_controller: RTL and testbench

- Sequences audio sample playback from flash for the audio player.
- Sits between the keyboard interface (which supplies play_enable, direction and restart) and the flash read port / audio output.
- Issues 32-bit word reads over a waitrequest/readdatavalid handshake and splits each word into two 16-bit samples.
- Emits one sample per sample-rate tick, stepping the address forward or backward, with wrap-around.

---
 rtl/flash_playback_pkg.sv | 10 +
 rtl/flash_word_reader.sv | 48 ++++
 rtl/flash_playback_controller.sv | 106 ++++++++++
 tb/tb_flash_playback_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_playback_pkg.sv
// flash_playback_pkg: shared state encoding and constants for flash audio playback.
// No ports; imported by flash_word_reader and flash_playback_controller.
package flash_playback_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, SAMPLE0, SAMPLE1, ADVANCE} state_t;
    localparam logic FORWARD = 1'b0;
    localparam logic BACKWARD = 1'b1;
    localparam logic [22:0] DEFAULT_START_ADDR = 23'h000000;
    localparam logic [22:0] DEFAULT_END_ADDR = 23'h07FFFF;
    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;
endpackage

// File: rtl/flash_word_reader.sv
// flash_word_reader: issues one 32-bit flash read and returns the word with a done pulse.
// Ports: clk_in/reset (async active-low); start + addr begin a read when idle;
// read/address/waitrequest/readdatavalid/readdata form the flash handshake;
// accept flags the cycle the request is taken; word holds the data, done pulses once per word.
module flash_word_reader
    import flash_playback_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter logic [ADDR_W-1:0] RESET_ADDR = DEFAULT_START_ADDR
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              waitrequest,
    input  logic              readdatavalid,
    input  logic [31:0]       readdata,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic              accept,
    output logic [31:0]       word,
    output logic              done
);
    logic waiting;
    assign accept = read && !waitrequest;
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            read <= 1'b0;
            waiting <= 1'b0;
            address <= RESET_ADDR;
            word <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !read && !waiting) begin
                read <= 1'b1;
                address <= addr;
            end else if (accept) begin
                read <= 1'b0;
                waiting <= 1'b1;
            end else if (waiting && readdatavalid) begin
                waiting <= 1'b0;
                word <= readdata;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/flash_playback_controller.sv
// flash_playback_controller: plays 16-bit samples from flash words, forward or backward, with wrap.
// Ports: clk_in/reset (async active-low); play_enable, direction, restart from the keyboard;
// sample_tick at audio rate; flash_mem_* read port; audio_data/audio_valid sample output;
// vol_shift (arithmetic attenuation) exists only when VOLUME_SCALE_EN is defined.
module flash_playback_controller
    import flash_playback_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = DEFAULT_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR = DEFAULT_END_ADDR
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              play_enable,
    input  logic              direction,
    input  logic              restart,
    input  logic              sample_tick,
`ifdef VOLUME_SCALE_EN
    input  logic [2:0]        vol_shift,
`endif
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [31:0]       flash_mem_readdata,
    output logic [15:0]       audio_data,
    output logic              audio_valid
);
    state_t state;
    logic [ADDR_W-1:0] address, home, next_addr;
    logic order, pending, accept, done;
    logic [31:0] word;
    logic [15:0] sel, scaled;
    assign flash_mem_byteenable = BYTEENABLE_ALL;
    assign home = (direction == BACKWARD) ? END_ADDR : START_ADDR;
    assign next_addr = (direction == BACKWARD)
        ? ((address == START_ADDR) ? END_ADDR : address - ADDR_W'(1))
        : ((address == END_ADDR) ? START_ADDR : address + ADDR_W'(1));
    // order is the direction latched for this word, so a backward word plays its upper half first
    assign sel = ((state == SAMPLE1) ^ order) ? word[31:16] : word[15:0];
`ifdef VOLUME_SCALE_EN
    assign scaled = $signed(sel) >>> vol_shift;
`else
    assign scaled = sel;
`endif
    flash_word_reader #(.ADDR_W(ADDR_W), .RESET_ADDR(START_ADDR)) u_reader (
        .clk_in(clk_in),
        .reset(reset),
        .start(state == REQ),
        .addr(address),
        .waitrequest(flash_mem_waitrequest),
        .readdatavalid(flash_mem_readdatavalid),
        .readdata(flash_mem_readdata),
        .read(flash_mem_read),
        .address(flash_mem_address),
        .accept(accept),
        .word(word),
        .done(done)
    );
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            address <= START_ADDR;
            order <= FORWARD;
            pending <= 1'b0;
            audio_data <= '0;
            audio_valid <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    pending <= pending | restart;
                    if (accept) state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (!done) pending <= pending | restart;
                    else if (pending || restart) begin
                        address <= home;
                        pending <= 1'b0;
                        state <= REQ;
                    end else begin
                        order <= direction;
                        state <= SAMPLE0;
                    end
                end
                SAMPLE0, SAMPLE1: begin
                    if (restart) begin
                        address <= home;
                        state <= REQ;
                    end else if (sample_tick && play_enable) begin
                        audio_data <= scaled;
                        audio_valid <= 1'b1;
                        state <= (state == SAMPLE0) ? SAMPLE1 : ADVANCE;
                    end
                end
                ADVANCE: begin
                    address <= restart ? home : next_addr;
                    state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_playback_controller.sv
// tb_flash_playback_controller: randomized self-checking bench with a flash slave and sample-order model.
module tb_flash_playback_controller;
    logic clk_in = 0, reset = 0, play_enable = 0, direction = 0, restart = 0, sample_tick = 0;
    logic flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0] flash_mem_byteenable;
    logic flash_mem_waitrequest = 0, flash_mem_readdatavalid = 0;
    logic [31:0] flash_mem_readdata = 0;
    logic [15:0] audio_data;
    logic audio_valid;
`ifdef VOLUME_SCALE_EN
    logic [2:0] vol_shift = 0;
`endif
    int n_cmp = 0, n_bad = 0;
    logic [31:0] mem [int unsigned];
    int unsigned read_log[$];
    logic [15:0] got[$];
    int ws_min = 0, ws_max = 0, lat_min = 1, lat_max = 1;
    bit auto_tick = 0;

    always #5 clk_in = ~clk_in;

    flash_playback_controller dut (
        .clk_in(clk_in),
        .reset(reset),
        .play_enable(play_enable),
        .direction(direction),
        .restart(restart),
        .sample_tick(sample_tick),
`ifdef VOLUME_SCALE_EN
        .vol_shift(vol_shift),
`endif
        .flash_mem_read(flash_mem_read),
        .flash_mem_address(flash_mem_address),
        .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_readdata(flash_mem_readdata),
        .audio_data(audio_data),
        .audio_valid(audio_valid)
    );

    function automatic logic [31:0] word_at(int unsigned a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // flash slave: random wait states, random read latency, logs each accepted address
    initial begin
        int ws, lat;
        bit busy;
        int unsigned a;
        ws = 0; lat = 0; busy = 0; a = 0;
        forever begin
            @(negedge clk_in);
            flash_mem_readdatavalid = 0;
            if (!reset) begin
                busy = 0; lat = 0; flash_mem_waitrequest = 0;
            end else begin
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        flash_mem_readdatavalid = 1;
                        flash_mem_readdata = word_at(a);
                    end
                end
                if (flash_mem_read) begin
                    if (!busy) begin busy = 1; ws = $urandom_range(ws_max, ws_min); end
                    if (ws > 0) begin
                        flash_mem_waitrequest = 1;
                        ws--;
                    end else begin
                        flash_mem_waitrequest = 0;
                        busy = 0;
                        a = flash_mem_address;
                        lat = $urandom_range(lat_max, lat_min);
                        read_log.push_back(a);
                    end
                end else flash_mem_waitrequest = 0;
            end
        end
    end

    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk_in);
            if (auto_tick) begin
                sample_tick = !prev && ($urandom_range(1, 0) == 1);
                prev = sample_tick;
            end else if (prev) begin
                sample_tick = 0;
                prev = 0;
            end
        end
    end

    always @(negedge clk_in) if (audio_valid) got.push_back(audio_data);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic dir);
        @(negedge clk_in);
        reset = 0; restart = 0; auto_tick = 0; direction = dir; play_enable = 1;
        repeat (3) @(negedge clk_in);
        sample_tick = 0;
        read_log.delete();
        got.delete();
        reset = 1;
    endtask

    task automatic pulse_tick();
        @(negedge clk_in);
        sample_tick = 1;
        @(negedge clk_in);
        sample_tick = 0;
    endtask

    task automatic wait_word(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk_in);
            #1 ok = flash_mem_readdatavalid;
        end
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_data_timeout: got no readdatavalid want one", name); end
    endtask

    task automatic wait_reads(input int n, input string name);
        for (int c = 0; c < 300 && read_log.size() < n; c++) @(negedge clk_in);
        n_cmp++;
        if (read_log.size() < n) begin
            n_bad++;
            $display("FAIL %s_read_timeout: got %0d reads want %0d", name, read_log.size(), n);
        end
    endtask

    task automatic test_reset();
        bit seen;
        seen = 0;
        reset = 1; play_enable = 1;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk_in); seen = flash_mem_read; end
        reset = 0;
        #1;
        n_cmp++; if (flash_mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %b want 0", flash_mem_read); end
        n_cmp++; if (audio_data !== 16'h0) begin n_bad++; $display("FAIL reset_audio_data: got %h want 0000", audio_data); end
        n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL reset_audio_valid: got %b want 0", audio_valid); end
        n_cmp++; if (flash_mem_address !== 23'h0) begin n_bad++; $display("FAIL reset_address: got %h want 000000", flash_mem_address); end
        n_cmp++; if (flash_mem_byteenable !== 4'hF) begin n_bad++; $display("FAIL reset_byteenable: got %h want f", flash_mem_byteenable); end
        do_reset(0);
        wait_reads(1, "reset_first");
        n_cmp++;
        if (read_log.size() > 0 && read_log[0] !== 0) begin n_bad++; $display("FAIL reset_first_addr: got %h want 0", read_log[0]); end
    endtask

    task automatic test_forward();
        do_reset(0);
        mem[0] = 32'hBBBB_AAAA;
        ws_min = 3; ws_max = 3; lat_min = 1; lat_max = 2;
        wait_word("fwd");
        pulse_tick();
        n_cmp++; if (audio_valid !== 1'b1 || audio_data !== 16'hAAAA) begin n_bad++; $display("FAIL fwd_s0: got valid=%b data=%h want valid=1 data=aaaa", audio_valid, audio_data); end
        @(negedge clk_in);
        n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_s0_pulse: got valid=%b want 0", audio_valid); end
        pulse_tick();
        n_cmp++; if (audio_valid !== 1'b1 || audio_data !== 16'hBBBB) begin n_bad++; $display("FAIL fwd_s1: got valid=%b data=%h want valid=1 data=bbbb", audio_valid, audio_data); end
        @(negedge clk_in);
        n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_s1_pulse: got valid=%b want 0", audio_valid); end
        wait_reads(2, "fwd_next");
        n_cmp++; if (read_log.size() > 1 && read_log[1] !== 1) begin n_bad++; $display("FAIL fwd_next_addr: got %h want 1", read_log[1]); end
        ws_min = 0; ws_max = 2;
    endtask

    task automatic test_backward_wrap();
        logic [31:0] w;
        do_reset(1);
        w = word_at(0);
        wait_word("bwd");
        pulse_tick();
        n_cmp++; if (audio_valid !== 1'b1 || audio_data !== w[31:16]) begin n_bad++; $display("FAIL bwd_s0: got valid=%b data=%h want valid=1 data=%h", audio_valid, audio_data, w[31:16]); end
        pulse_tick();
        n_cmp++; if (audio_valid !== 1'b1 || audio_data !== w[15:0]) begin n_bad++; $display("FAIL bwd_s1: got valid=%b data=%h want valid=1 data=%h", audio_valid, audio_data, w[15:0]); end
        wait_reads(2, "bwd_wrap");
        n_cmp++; if (read_log.size() > 1 && read_log[1] !== 23'h7FFFF) begin n_bad++; $display("FAIL bwd_wrap_addr: got %h want 7ffff", read_log[1]); end
    endtask

    task automatic test_pause();
        logic [31:0] w;
        do_reset(0);
        w = word_at(0);
        wait_word("pause");
        play_enable = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            n_cmp++;
            if (audio_valid !== 1'b0 || audio_data !== 16'h0) begin n_bad++; $display("FAIL pause_tick%0d: got valid=%b data=%h want valid=0 data=0000", i, audio_valid, audio_data); end
        end
        play_enable = 1;
        pulse_tick();
        n_cmp++; if (audio_valid !== 1'b1 || audio_data !== w[15:0]) begin n_bad++; $display("FAIL pause_resume: got valid=%b data=%h want valid=1 data=%h", audio_valid, audio_data, w[15:0]); end
    endtask

    task automatic test_restart_in_sample();
        do_reset(0);
        wait_word("rs");
        direction = 1;
        @(negedge clk_in);
        restart = 1; sample_tick = 1;
        @(negedge clk_in);
        restart = 0; sample_tick = 0;
        n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL rs_no_sample: got valid=%b want 0", audio_valid); end
        wait_reads(2, "rs_home");
        n_cmp++; if (read_log.size() > 1 && read_log[1] !== 23'h7FFFF) begin n_bad++; $display("FAIL rs_home_addr: got %h want 7ffff", read_log[1]); end
        direction = 0;
    endtask

    task automatic test_walk_restart();
        bit found;
        logic [31:0] w;
        int n;
        do_reset(0);
        mem[256] = 32'h1234_5678;
        ws_min = 0; ws_max = 2; lat_min = 3; lat_max = 3;
        auto_tick = 1;
        found = 0;
        for (int c = 0; c < 20000 && !found; c++) begin
            @(posedge clk_in);
            #1 found = read_log.size() > 0 && read_log[$] == 256;
        end
        @(negedge clk_in);
        restart = 1;
        @(negedge clk_in);
        restart = 0;
        n_cmp++; if (!found) begin n_bad++; $display("FAIL walk_reach_0x100: got %0d reads want read at 100", read_log.size()); end
        n = got.size();
        n_cmp++; if (n !== 512) begin n_bad++; $display("FAIL walk_count: got %0d samples want 512", n); end
        for (int i = 0; i < n && i < 512; i++) begin
            w = word_at(i / 2);
            n_cmp++;
            if (got[i] !== ((i % 2) ? w[31:16] : w[15:0])) begin n_bad++; $display("FAIL walk_sample%0d: got %h want %h", i, got[i], (i % 2) ? w[31:16] : w[15:0]); end
        end
        for (int i = 0; i < read_log.size() && i < 257; i++) begin
            n_cmp++;
            if (read_log[i] !== i) begin n_bad++; $display("FAIL walk_addr%0d: got %h want %h", i, read_log[i], i); end
        end
        got.delete();
        wait_reads(258, "walk_restart");
        n_cmp++; if (read_log.size() > 257 && read_log[257] !== 0) begin n_bad++; $display("FAIL walk_restart_addr: got %h want 0", read_log[257]); end
        for (int c = 0; c < 300 && got.size() < 2; c++) @(negedge clk_in);
        auto_tick = 0;
        w = word_at(0);
        n_cmp++;
        if (got.size() < 2 || got[0] !== w[15:0] || got[1] !== w[31:16]) begin
            n_bad++;
            $display("FAIL walk_restart_samples: got %0d samples first=%h want %h then %h", got.size(), got.size() > 0 ? got[0] : 16'h0, w[15:0], w[31:16]);
        end
        lat_min = 1; lat_max = 2;
    endtask

`ifdef VOLUME_SCALE_EN
    task automatic test_volume();
        do_reset(0);
        mem[0] = 32'h0000_8000;
        vol_shift = 2;
        wait_word("vol");
        pulse_tick();
        n_cmp++; if (audio_valid !== 1'b1 || audio_data !== 16'hE000) begin n_bad++; $display("FAIL vol_shift2: got valid=%b data=%h want valid=1 data=e000", audio_valid, audio_data); end
        vol_shift = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_backward_wrap();
        test_pause();
        test_restart_in_sample();
        test_walk_restart();
`ifdef VOLUME_SCALE_EN
        test_volume();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
